// File: rtl/pipe_ctrl.sv
// Stall/flush controller for the 5-stage core: stage write enables and per-stage valid bits.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             lu_hazard_rs1_i,
    input  logic             lu_hazard_rs2_i,
    input  logic             branch_taken_i,
    input  logic             if_ready_i,
    input  logic             mem_busy_i,
    output logic             pc_we_o,
    output logic             if_id_we_o,
    output logic             id_ex_we_o,
    output logic             ex_mem_we_o,
    output logic             mem_wb_we_o,
    output logic             id_valid_o,
    output logic             ex_valid_o,
    output logic             mem_valid_o,
    output logic             wb_valid_o,
    output logic [CNT_W-1:0] stall_lu_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic [2:0] {
        MODE_RUN        = 3'd0,
        MODE_FETCH_WAIT = 3'd1,
        MODE_LU_STALL   = 3'd2,
        MODE_FLUSH      = 3'd3,
        MODE_FREEZE     = 3'd4
    } mode_t;

    mode_t      mode;
    logic       lu;
    logic [4:0] we;

    // A hazard only matters when ID actually holds an instruction.
    assign lu = (lu_hazard_rs1_i | lu_hazard_rs2_i) & id_valid_o;

    // Priority decode of this cycle's pipeline condition.
    always_comb begin
        mode = MODE_RUN;
        if (mem_busy_i) begin
            mode = MODE_FREEZE;
        end else if (branch_taken_i) begin
            mode = MODE_FLUSH;
        end else if (lu) begin
            mode = MODE_LU_STALL;
        end else if (!if_ready_i) begin
            mode = MODE_FETCH_WAIT;
        end else begin
            mode = MODE_RUN;
        end
    end

    // Write enables, ordered {pc, if_id, id_ex, ex_mem, mem_wb}.
    always_comb begin
        we = 5'b00000;
        case (mode)
            MODE_FREEZE:     we = 5'b00000;
            MODE_FLUSH:      we = 5'b11111;
            MODE_LU_STALL:   we = 5'b00111;
            MODE_FETCH_WAIT: we = 5'b01111;
            MODE_RUN:        we = 5'b11111;
            default:         we = 5'b00000;
        endcase
    end

    assign pc_we_o     = we[4];
    assign if_id_we_o  = we[3];
    assign id_ex_we_o  = we[2];
    assign ex_mem_we_o = we[1];
    assign mem_wb_we_o = we[0];

    // Per-stage valid bits advance with the pipeline registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            id_valid_o  <= 1'b0;
            ex_valid_o  <= 1'b0;
            mem_valid_o <= 1'b0;
            wb_valid_o  <= 1'b0;
        end else begin
            case (mode)
                MODE_FREEZE: begin
                    id_valid_o  <= id_valid_o;
                    ex_valid_o  <= ex_valid_o;
                    mem_valid_o <= mem_valid_o;
                    wb_valid_o  <= wb_valid_o;
                end
                MODE_FLUSH: begin
                    id_valid_o  <= 1'b0;
                    ex_valid_o  <= 1'b0;
                    mem_valid_o <= ex_valid_o;
                    wb_valid_o  <= mem_valid_o;
                end
                MODE_LU_STALL: begin
                    id_valid_o  <= id_valid_o;
                    ex_valid_o  <= 1'b0;
                    mem_valid_o <= ex_valid_o;
                    wb_valid_o  <= mem_valid_o;
                end
                MODE_FETCH_WAIT: begin
                    id_valid_o  <= 1'b0;
                    ex_valid_o  <= id_valid_o;
                    mem_valid_o <= ex_valid_o;
                    wb_valid_o  <= mem_valid_o;
                end
                MODE_RUN: begin
                    id_valid_o  <= 1'b1;
                    ex_valid_o  <= id_valid_o;
                    mem_valid_o <= ex_valid_o;
                    wb_valid_o  <= mem_valid_o;
                end
                default: begin
                    id_valid_o  <= 1'b0;
                    ex_valid_o  <= 1'b0;
                    mem_valid_o <= 1'b0;
                    wb_valid_o  <= 1'b0;
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Event counters; FREEZE is excluded by the mode decode itself.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_lu_cnt_o <= {CNT_W{1'b0}};
            flush_cnt_o    <= {CNT_W{1'b0}};
        end else begin
            if (mode == MODE_LU_STALL) begin
                stall_lu_cnt_o <= sat_inc(stall_lu_cnt_o);
            end else begin
                stall_lu_cnt_o <= stall_lu_cnt_o;
            end
            if (mode == MODE_FLUSH) begin
                flush_cnt_o <= sat_inc(flush_cnt_o);
            end else begin
                flush_cnt_o <= flush_cnt_o;
            end
        end
    end
`else
    assign stall_lu_cnt_o = {CNT_W{1'b0}};
    assign flush_cnt_o    = {CNT_W{1'b0}};
`endif

endmodule
